// File: rtl/injector_bank_if.sv
// Bundle of per-channel command/status signals between the fuel scheduler and
// the injector bank; clock and reset stay outside as plain ports.
interface injector_bank_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16
);
    logic [N_CH-1:0]  i_enable;
    logic [N_CH-1:0]  i_peak_hit;
    logic [CNT_W-1:0] i_peak_cycles;
    logic [CNT_W-1:0] i_hold_period;
    logic [CNT_W-1:0] i_hold_on;
    logic [N_CH-1:0]  i_fault_clr;
    logic [N_CH-1:0]  o_drive;
    logic [N_CH-1:0]  o_flyback;
    logic [N_CH-1:0]  o_busy;
    logic [N_CH-1:0]  o_fault;

    modport master (
        output i_enable, i_peak_hit, i_peak_cycles, i_hold_period, i_hold_on, i_fault_clr,
        input  o_drive, o_flyback, o_busy, o_fault
    );

    modport slave (
        input  i_enable, i_peak_hit, i_peak_cycles, i_hold_period, i_hold_on, i_fault_clr,
        output o_drive, o_flyback, o_busy, o_fault
    );
endinterface

// File: rtl/injector_bank.sv
// N-channel peak-and-hold injector driver: one independent PEAK/HOLD/FLYBACK
// timing engine per channel with a sticky over-on-time fault.
module injector_ch #(
    parameter int CNT_W          = 16,
    parameter int FLYBACK_CYCLES = 200,
    parameter int MAX_ON_CYCLES  = 60000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic             i_peak_hit,
    input  logic             i_fault_clr,
    input  logic [CNT_W-1:0] i_peak_cycles,
    input  logic [CNT_W-1:0] i_hold_period,
    input  logic [CNT_W-1:0] i_hold_on,
    output logic             o_drive,
    output logic             o_flyback,
    output logic             o_busy,
    output logic             o_fault
);
    localparam int FB_W = $clog2(FLYBACK_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, PEAK, HOLD, FLYBACK} state_e;

    state_e           state_q;
    logic             en_q, arm_q, drive_q, flyback_q, busy_q, fault_q;
    logic [CNT_W-1:0] peak_n_q, period_q, hon_q;
    logic [CNT_W-1:0] peak_cnt_q, phase_q, on_cnt_q;
    logic [FB_W-1:0]  fb_cnt_q;

    logic             rise, on_limit, peak_done;
    logic [CNT_W-1:0] phase_d, period_in;

    // arm_q blocks a level that was already high out of reset from looking like a rise
    assign rise      = i_enable & ~en_q & arm_q;
    assign on_limit  = (on_cnt_q == CNT_W'(MAX_ON_CYCLES - 1));
    assign peak_done = i_peak_hit | (peak_cnt_q == peak_n_q - CNT_W'(1));
    assign phase_d   = (phase_q == period_q - CNT_W'(1)) ? '0 : phase_q + CNT_W'(1);
    assign period_in = (i_hold_period == '0) ? CNT_W'(1) : i_hold_period;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            en_q       <= 1'b0;
            arm_q      <= 1'b0;
            drive_q    <= 1'b0;
            flyback_q  <= 1'b0;
            busy_q     <= 1'b0;
            fault_q    <= 1'b0;
            peak_n_q   <= '0;
            period_q   <= '0;
            hon_q      <= '0;
            peak_cnt_q <= '0;
            phase_q    <= '0;
            on_cnt_q   <= '0;
            fb_cnt_q   <= '0;
        end else begin
            en_q <= i_enable;
            if (!i_enable) arm_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (i_fault_clr) fault_q <= 1'b0;
                    if (rise && !fault_q) begin
                        peak_n_q   <= i_peak_cycles;
                        period_q   <= period_in;
                        hon_q      <= i_hold_on;
                        peak_cnt_q <= '0;
                        phase_q    <= '0;
                        on_cnt_q   <= '0;
                        busy_q     <= 1'b1;
                        if (i_peak_cycles == '0) begin
                            state_q <= HOLD;
                            drive_q <= (i_hold_on != '0);
                        end else begin
                            state_q <= PEAK;
                            drive_q <= 1'b1;
                        end
                    end
                end
                PEAK, HOLD: begin
                    on_cnt_q <= on_cnt_q + CNT_W'(1);
                    if (!i_enable || on_limit) begin
                        // enable-low wins over the fault when both land together
                        state_q   <= FLYBACK;
                        drive_q   <= 1'b0;
                        flyback_q <= 1'b1;
                        fb_cnt_q  <= '0;
                        if (i_enable) fault_q <= 1'b1;
                    end else if (state_q == PEAK) begin
                        peak_cnt_q <= peak_cnt_q + CNT_W'(1);
                        if (peak_done) begin
                            state_q <= HOLD;
                            phase_q <= '0;
                            drive_q <= (hon_q != '0);
                        end
                    end else begin
                        phase_q <= phase_d;
                        drive_q <= (phase_d < hon_q);
                    end
                end
                FLYBACK: begin
                    fb_cnt_q <= fb_cnt_q + FB_W'(1);
                    if (fb_cnt_q == FB_W'(FLYBACK_CYCLES - 1)) begin
                        state_q   <= IDLE;
                        flyback_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_drive   = drive_q;
    assign o_flyback = flyback_q;
    assign o_busy    = busy_q;
    assign o_fault   = fault_q;
endmodule

module injector_bank #(
    parameter int N_CH           = 4,
    parameter int CNT_W          = 16,
    parameter int FLYBACK_CYCLES = 200,
    parameter int MAX_ON_CYCLES  = 60000
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    injector_bank_if.slave bus
);
    // timing inputs are shared; each channel latches its own copy at pulse start
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        injector_ch #(
            .CNT_W         (CNT_W),
            .FLYBACK_CYCLES(FLYBACK_CYCLES),
            .MAX_ON_CYCLES (MAX_ON_CYCLES)
        ) u_ch (
            .i_clk        (i_clk),
            .i_rst_n      (i_rst_n),
            .i_enable     (bus.i_enable[g]),
            .i_peak_hit   (bus.i_peak_hit[g]),
            .i_fault_clr  (bus.i_fault_clr[g]),
            .i_peak_cycles(bus.i_peak_cycles),
            .i_hold_period(bus.i_hold_period),
            .i_hold_on    (bus.i_hold_on),
            .o_drive      (bus.o_drive[g]),
            .o_flyback    (bus.o_flyback[g]),
            .o_busy       (bus.o_busy[g]),
            .o_fault      (bus.o_fault[g])
        );
    end
endmodule

// File: tb/tb_injector_bank.sv
// Random and directed stimulus for injector_bank, checked every cycle against a
// pulse-timeline reference model (time since drive start, peak length, flyback left).
module tb_injector_bank;
    localparam int N = 4, W = 16, FB = 200, MAXON = 60000;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    injector_bank_if #(.N_CH(N), .CNT_W(W)) bus();

    injector_bank #(.N_CH(N), .CNT_W(W), .FLYBACK_CYCLES(FB), .MAX_ON_CYCLES(MAXON)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    // reference model: a pulse is a timeline t=0,1,.. of on-cycles; first plen are full-on
    bit m_on [N];
    bit m_fault [N];
    bit m_prev [N];
    bit m_arm [N];
    int m_t [N];
    int m_plen [N];
    int m_per [N];
    int m_hon [N];
    int m_fb [N];

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_on[c] = 0; m_fault[c] = 0; m_prev[c] = 0; m_arm[c] = 0;
            m_t[c] = 0; m_plen[c] = 0; m_per[c] = 1; m_hon[c] = 0; m_fb[c] = 0;
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < N; c++) begin
            bit en;
            en = bus.i_enable[c];
            if (m_on[c]) begin
                if (!en) begin
                    m_on[c] = 0; m_fb[c] = FB;
                end else if (m_t[c] + 1 == MAXON) begin
                    m_on[c] = 0; m_fb[c] = FB; m_fault[c] = 1;
                end else begin
                    if (bus.i_peak_hit[c] && m_t[c] < m_plen[c]) m_plen[c] = m_t[c] + 1;
                    m_t[c]++;
                end
            end else if (m_fb[c] > 0) begin
                m_fb[c]--;
            end else begin
                if (en && !m_prev[c] && m_arm[c] && !m_fault[c]) begin
                    m_on[c]   = 1;
                    m_t[c]    = 0;
                    m_plen[c] = int'(bus.i_peak_cycles);
                    m_per[c]  = (bus.i_hold_period == 0) ? 1 : int'(bus.i_hold_period);
                    m_hon[c]  = int'(bus.i_hold_on);
                end
                if (bus.i_fault_clr[c]) m_fault[c] = 0;
            end
            m_prev[c] = en;
            if (!en) m_arm[c] = 1;
        end
    endtask

    function automatic logic [4*N-1:0] expv();
        logic [N-1:0] d, f, b, ft;
        for (int c = 0; c < N; c++) begin
            d[c]  = m_on[c] && (m_t[c] < m_plen[c] || ((m_t[c] - m_plen[c]) % m_per[c]) < m_hon[c]);
            f[c]  = m_fb[c] > 0;
            b[c]  = m_on[c] || (m_fb[c] > 0);
            ft[c] = m_fault[c];
        end
        return {d, f, b, ft};
    endfunction

    function automatic logic [4*N-1:0] obsv();
        return {bus.o_drive, bus.o_flyback, bus.o_busy, bus.o_fault};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_enable = '0; bus.i_peak_hit = '0; bus.i_fault_clr = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.i_peak_cycles = 0; bus.i_hold_period = 0; bus.i_hold_on = 0;
        #2 rst_n = 1'b0;
        repeat (3) tick();
        total++;
        if (obsv() !== '0) begin bad++; $display("FAIL reset_state got=%h exp=0", obsv()); end
        #3 rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            total++;
            if (obsv() !== expv()) begin bad++; $display("FAIL reset_idle k=%0d got=%h exp=%h", k, obsv(), expv()); end
        end
    endtask

    task automatic test_peak_hold();
        int fly = 0;
        bus.i_peak_cycles = 10; bus.i_hold_period = 8; bus.i_hold_on = 3;
        for (int k = 1; k <= 270; k++) begin
            bus.i_enable[0] = (k <= 60);
            tick();
            total++;
            if (obsv() !== expv()) begin bad++; $display("FAIL peak_hold k=%0d got=%h exp=%h", k, obsv(), expv()); end
            if (k <= 60) begin
                logic want;
                want = (k <= 10) || (((k - 11) % 8) < 3);
                total++;
                if (bus.o_drive[0] !== want) begin bad++; $display("FAIL peak_hold_drive k=%0d got=%b exp=%b", k, bus.o_drive[0], want); end
            end
            if (bus.o_flyback[0]) fly++;
            if (k == 260 || k == 261) begin
                total++;
                if (bus.o_busy[0] !== (k == 260)) begin bad++; $display("FAIL peak_hold_busy k=%0d got=%b exp=%b", k, bus.o_busy[0], k == 260); end
            end
        end
        total++;
        if (fly != FB) begin bad++; $display("FAIL flyback_len got=%0d exp=%0d", fly, FB); end
    endtask

    task automatic test_peak_hit();
        int drv = 0;
        bus.i_peak_cycles = 100; bus.i_hold_period = 8; bus.i_hold_on = 0;
        for (int k = 1; k <= 230; k++) begin
            bus.i_enable[0]   = (k <= 20);
            bus.i_peak_hit[0] = (k == 9);
            tick();
            total++;
            if (obsv() !== expv()) begin bad++; $display("FAIL peak_hit k=%0d got=%h exp=%h", k, obsv(), expv()); end
            if (k <= 20 && bus.o_drive[0]) drv++;
        end
        total++;
        if (drv != 8) begin bad++; $display("FAIL peak_hit_len got=%0d exp=8", drv); end
    endtask

    task automatic test_fault();
        int first = 0;
        bus.i_peak_cycles = 10; bus.i_hold_period = 4; bus.i_hold_on = 2;
        for (int k = 1; k <= 60300; k++) begin
            bus.i_enable[2]    = 1'b1;
            bus.i_fault_clr[2] = (k >= 60010 && k <= 60020);
            tick();
            total++;
            if (obsv() !== expv()) begin bad++; $display("FAIL fault_run k=%0d got=%h exp=%h", k, obsv(), expv()); end
            if (first == 0 && bus.o_fault[2]) first = k;
        end
        bus.i_fault_clr[2] = 1'b0;
        total++;
        if (first != MAXON + 1) begin bad++; $display("FAIL fault_time got=%0d exp=%0d", first, MAXON + 1); end
        for (int k = 0; k < 12; k++) begin
            bus.i_enable[2] = (k != 0);
            tick();
            total++;
            if (obsv() !== expv()) begin bad++; $display("FAIL fault_norefire k=%0d got=%h exp=%h", k, obsv(), expv()); end
        end
        total++;
        if ({bus.o_busy[2], bus.o_fault[2]} !== 2'b01) begin bad++; $display("FAIL fault_blocked got=%b exp=01", {bus.o_busy[2], bus.o_fault[2]}); end
        bus.i_enable[2] = 1'b0;
        tick();
        bus.i_fault_clr[2] = 1'b1;
        tick();
        bus.i_fault_clr[2] = 1'b0;
        total++;
        if (bus.o_fault[2] !== 1'b0) begin bad++; $display("FAIL fault_clear got=%b exp=0", bus.o_fault[2]); end
        bus.i_enable[2] = 1'b1;
        tick();
        total++;
        if (bus.o_drive[2] !== 1'b1) begin bad++; $display("FAIL fault_refire got=%b exp=1", bus.o_drive[2]); end
        for (int k = 0; k < 230; k++) begin
            bus.i_enable[2] = (k < 20);
            tick();
            total++;
            if (obsv() !== expv()) begin bad++; $display("FAIL fault_after k=%0d got=%h exp=%h", k, obsv(), expv()); end
        end
    endtask

    task automatic test_skip_peak();
        for (int pass = 0; pass < 2; pass++) begin
            int drv = 0;
            bus.i_peak_cycles = 0;
            bus.i_hold_period = (pass == 0) ? 0 : 4;
            bus.i_hold_on     = (pass == 0) ? 0 : 8;
            for (int k = 1; k <= 240; k++) begin
                bus.i_enable[1] = (k <= 30);
                tick();
                total++;
                if (obsv() !== expv()) begin bad++; $display("FAIL skip_peak p=%0d k=%0d got=%h exp=%h", pass, k, obsv(), expv()); end
                if (k <= 30 && bus.o_drive[1]) drv++;
                if (k == 1) begin
                    total++;
                    if (bus.o_busy[1] !== 1'b1) begin bad++; $display("FAIL skip_peak_busy p=%0d got=%b exp=1", pass, bus.o_busy[1]); end
                end
            end
            total++;
            if (drv != ((pass == 0) ? 0 : 30)) begin bad++; $display("FAIL skip_peak_duty p=%0d got=%0d exp=%0d", pass, drv, (pass == 0) ? 0 : 30); end
        end
    endtask

    task automatic test_async_reset();
        bus.i_peak_cycles = 5; bus.i_hold_period = 4; bus.i_hold_on = 2;
        for (int k = 1; k <= 20; k++) begin
            bus.i_enable[1] = 1'b1;
            tick();
            total++;
            if (obsv() !== expv()) begin bad++; $display("FAIL areset_pre k=%0d got=%h exp=%h", k, obsv(), expv()); end
        end
        total++;
        if (bus.o_busy[1] !== 1'b1) begin bad++; $display("FAIL areset_busy got=%b exp=1", bus.o_busy[1]); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (obsv() !== '0) begin bad++; $display("FAIL areset_async got=%h exp=0", obsv()); end
        repeat (3) tick();
        #3 rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            total++;
            if (obsv() !== expv()) begin bad++; $display("FAIL areset_post k=%0d got=%h exp=%h", k, obsv(), expv()); end
        end
        total++;
        if (bus.o_busy[1] !== 1'b0) begin bad++; $display("FAIL areset_nofire got=%b exp=0", bus.o_busy[1]); end
        for (int k = 0; k < 240; k++) begin
            bus.i_enable[1] = (k >= 5 && k < 30);
            tick();
            total++;
            if (obsv() !== expv()) begin bad++; $display("FAIL areset_refire k=%0d got=%h exp=%h", k, obsv(), expv()); end
            if (k == 5) begin
                total++;
                if (bus.o_drive[1] !== 1'b1) begin bad++; $display("FAIL areset_refire_drive got=%b exp=1", bus.o_drive[1]); end
            end
        end
    endtask

    task automatic test_stagger();
        int st [N] = '{5, 25, 45, 65};
        int du [N] = '{60, 90, 50, 120};
        for (int k = 0; k < 420; k++) begin
            if (k % 7 == 0) begin
                bus.i_peak_cycles = W'($urandom_range(30));
                bus.i_hold_period = W'($urandom_range(10));
                bus.i_hold_on     = W'($urandom_range(12));
            end
            for (int c = 0; c < N; c++) begin
                bus.i_enable[c]   = (k >= st[c] && k < st[c] + du[c]);
                bus.i_peak_hit[c] = ($urandom_range(24) == 0);
            end
            tick();
            total++;
            if (obsv() !== expv()) begin bad++; $display("FAIL stagger k=%0d got=%h exp=%h", k, obsv(), expv()); end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [N-1:0] en = '0;
        for (int k = 0; k < 6200; k++) begin
            if (k < 6000) begin
                for (int c = 0; c < N; c++) begin
                    if ($urandom_range(39) == 0) en[c] = ~en[c];
                    bus.i_peak_hit[c]  = ($urandom_range(15) == 0);
                    bus.i_fault_clr[c] = ($urandom_range(19) == 0);
                end
                if ($urandom_range(49) == 0) begin
                    bus.i_peak_cycles = W'($urandom_range(20));
                    bus.i_hold_period = W'($urandom_range(12));
                    bus.i_hold_on     = W'($urandom_range(14));
                end
            end else begin
                en = '0;
                bus.i_peak_hit = '0;
                bus.i_fault_clr = '0;
            end
            bus.i_enable = en;
            tick();
            total++;
            if (obsv() !== expv()) begin bad++; $display("FAIL random k=%0d got=%h exp=%h", k, obsv(), expv()); end
        end
        idle_inputs();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_peak_hold();
        test_peak_hit();
        test_fault();
        test_skip_peak();
        test_async_reset();
        test_stagger();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
